// File: rtl/sdes_gearbox_if.sv
// sdes_gearbox_if: word-side bundle of the lane gearbox.
//   dout/dout_valid : assembled receive word and its one-cycle strobe
//   din/din_valid   : transmit word offered by the core
//   din_ready       : gearbox takes din at this edge when din_valid is high
// slave modport is the gearbox view; master modport is the core view.
interface sdes_gearbox_if #(
    parameter int LANE_W = 16,
    parameter int RATIO  = 4
);
    localparam int WORD_W = LANE_W * RATIO;

    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic [WORD_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (
        input  dout,
        input  dout_valid,
        input  din_ready,
        output din,
        output din_valid
    );

    modport slave (
        output dout,
        output dout_valid,
        output din_ready,
        input  din,
        input  din_valid
    );
endinterface

// File: rtl/sdes_gearbox.sv
// sdes_gearbox: lane <-> word gearbox, full duplex, single clock.
// Receive: RATIO lanes of lane_in are packed into one word (slot k at
// [k*LANE_W +: LANE_W]) and presented on bus.dout with a one-cycle strobe.
// Transmit: a word taken from bus.din at a load opportunity is sent lane by
// lane on lane_out, slot 0 first. frame_clk_out toggles on each completed
// receive frame. underrun_cnt counts frame boundaries with no word offered.
// Ports:
//   in_clk, rst_n (async, active-low), align (realign to slot 0),
//   lane_in / lane_out / lane_vld (serial side),
//   bus (sdes_gearbox_if.slave, word side),
//   underrun_cnt (8-bit saturating), frame_clk_out.
// Optional build macro SDES_GEARBOX_LOOPBACK_EN adds input `loopback`; when
// high the receive path captures lane_out instead of lane_in.
//
// state  | meaning
// S_IDLE | out of reset; the next edge starts framing at slot 0
// S_RUN  | framing; slot advances every edge, wrapping after RATIO-1
module sdes_gearbox #(
    parameter int LANE_W = 16,
    parameter int RATIO  = 4
) (
    input  logic              in_clk,
    input  logic              rst_n,
    input  logic              align,
`ifdef SDES_GEARBOX_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic [LANE_W-1:0] lane_in,
    sdes_gearbox_if.slave     bus,
    output logic [LANE_W-1:0] lane_out,
    output logic              lane_vld,
    output logic [7:0]        underrun_cnt,
    output logic              frame_clk_out
);
    localparam int WORD_W = LANE_W * RATIO;
    localparam int SLOT_W = (RATIO <= 2) ? 1 : $clog2(RATIO);
    // The last lane of a frame goes straight into dout, so only RATIO-1
    // lanes need to be held.
    localparam int ACC_W  = LANE_W * (RATIO - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(RATIO - 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [WORD_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                lane_vld_q, lane_vld_d;
    logic [7:0]          underrun_q, underrun_d;
    logic                frame_clk_q, frame_clk_d;

    logic                at_last;
    logic                boundary;
    logic                load_opp;
    logic [LANE_W-1:0]   lane_sel;
    logic [LANE_W-1:0]   cap_lane;

    assign at_last  = (state_q == S_RUN) && (slot_q == SLOT_LAST);
    // Align overrides a frame boundary on the same edge.
    assign boundary = at_last && !align;
    assign load_opp = (state_q == S_IDLE) || align || at_last;

    always_comb begin
        lane_sel = '0;
        if (state_q == S_RUN) begin
            for (int k = 0; k < RATIO; k++) begin
                if (slot_q == SLOT_W'(k)) begin
                    lane_sel = hold_q[k*LANE_W +: LANE_W];
                end
            end
        end
    end

`ifdef SDES_GEARBOX_LOOPBACK_EN
    assign cap_lane = loopback ? lane_sel : lane_in;
`else
    assign cap_lane = lane_in;
`endif

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        acc_d        = acc_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        hold_d       = hold_q;
        lane_vld_d   = lane_vld_q;
        underrun_d   = underrun_q;
        frame_clk_d  = frame_clk_q;

        if (align || (state_q == S_IDLE)) begin
            // Restart framing; any partial receive word is dropped.
            state_d = S_RUN;
            slot_d  = '0;
        end else begin
            for (int k = 0; k < RATIO - 1; k++) begin
                if (slot_q == SLOT_W'(k)) begin
                    acc_d[k*LANE_W +: LANE_W] = cap_lane;
                end
            end
            if (at_last) begin
                slot_d       = '0;
                dout_d       = {cap_lane, acc_q};
                dout_valid_d = 1'b1;
                frame_clk_d  = ~frame_clk_q;
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end

        if (load_opp) begin
            if (bus.din_valid) begin
                hold_d     = bus.din;
                lane_vld_d = 1'b1;
            end else begin
                hold_d     = '0;
                lane_vld_d = 1'b0;
                if (boundary && (underrun_q != 8'hFF)) begin
                    underrun_d = underrun_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            hold_q       <= '0;
            lane_vld_q   <= 1'b0;
            underrun_q   <= 8'd0;
            frame_clk_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            acc_q        <= acc_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            hold_q       <= hold_d;
            lane_vld_q   <= lane_vld_d;
            underrun_q   <= underrun_d;
            frame_clk_q  <= frame_clk_d;
        end
    end

    assign bus.din_ready  = load_opp;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign lane_out       = lane_sel;
    assign lane_vld       = lane_vld_q;
    assign underrun_cnt   = underrun_q;
    assign frame_clk_out  = frame_clk_q;
endmodule
